axis_sync_fifo: RTL and testbench

- Synthesizable single-clock AXI-Stream FIFO. Sits between the testbench master, which drives its slave port, and the testbench slave, which sinks its master port.
- Accepts beats on the slave side, buffers up to DEPTH beats, and re-emits them in order on the master side.
- Absorbs independent valid/ready stalls on either side.
- Serves as the first synthesizable DUT for the AXIS agent environment.

---
 rtl/axis_sync_fifo.sv | 110 +++++++++++
 tb/tb_axis_sync_fifo.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/axis_sync_fifo.sv
// Single-clock AXI-Stream FIFO holding up to DEPTH beats, re-emitted in order.
// Latency: a beat accepted at edge N is presented on the master side after edge N (no bypass).
// Backpressure: s_axis_tready drops while full (no write-through); master side holds while m_axis_tready=0.
//
// Ports:
//   aclk, aresetn          clock (rising edge) and asynchronous active-low reset
//   s_axis_tdata/tvalid/tready   write-side AXI-Stream slave port
//   m_axis_tdata/tvalid/tready   read-side AXI-Stream master port
//   count                  current occupancy, 0..DEPTH
//   almost_full            registered flag, high while count >= ALMOST_FULL_LVL
module axis_sync_fifo #(
   parameter int TDATA_BYTES     = 1,
   parameter int DEPTH           = 8,
   parameter int ALMOST_FULL_LVL = DEPTH - 2
) (
   input  logic                         aclk,
   input  logic                         aresetn,

   input  logic [TDATA_BYTES*8-1:0]     s_axis_tdata,
   input  logic                         s_axis_tvalid,
   output logic                         s_axis_tready,

   output logic [TDATA_BYTES*8-1:0]     m_axis_tdata,
   output logic                         m_axis_tvalid,
   input  logic                         m_axis_tready,

   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         almost_full
);

   localparam int DW    = TDATA_BYTES * 8;
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] CNT_AF   = CNT_W'(ALMOST_FULL_LVL);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

   // Storage is deliberately not reset; only pointers and flags are.
   logic [DW-1:0]    mem [DEPTH];

   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_nxt;
   logic             tready_q;
   logic             tvalid_q;
   logic             af_q;

   logic             wr_en;
   logic             rd_en;

   // Handshakes use only the registered ready/valid, so neither side's
   // input can combinationally affect the other side's outputs.
   assign wr_en = s_axis_tvalid & tready_q;
   assign rd_en = m_axis_tready & tvalid_q;

   // Occupancy bookkeeping; a simultaneous push and pop cancel out.
   always_comb begin
      count_nxt = count_q;
      case ({wr_en, rd_en})
         2'b10:   count_nxt = count_q + CNT_ONE;
         2'b01:   count_nxt = count_q - CNT_ONE;
         default: count_nxt = count_q;
      endcase
   end

   // Control state. The flags are registered copies of conditions on the
   // next-state count, so they line up with count on every edge. tready_q
   // stays low throughout reset and rises on the first edge after release.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count_q  <= '0;
         tready_q <= 1'b0;
         tvalid_q <= 1'b0;
         af_q     <= 1'b0;
      end else begin
         if (wr_en) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (rd_en) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         count_q  <= count_nxt;
         // Full blocks writes for the whole cycle even if a pop happens,
         // so ready only returns on the edge after that pop.
         tready_q <= (count_nxt != CNT_FULL);
         tvalid_q <= (count_nxt != '0);
         af_q     <= (count_nxt >= CNT_AF);
      end
   end

   // Writes only land on slot wr_ptr; while count < DEPTH that slot is never
   // rd_ptr of a valid entry, so the presented beat stays stable under stall.
   always_ff @(posedge aclk) begin
      if (wr_en) begin
         mem[wr_ptr] <= s_axis_tdata;
      end
   end

   assign s_axis_tready = tready_q;
   assign m_axis_tvalid = tvalid_q;
   assign m_axis_tdata  = mem[rd_ptr];
   assign count         = count_q;
   assign almost_full   = af_q;

endmodule

// File: tb/tb_axis_sync_fifo.sv
module tb_axis_sync_fifo;

   localparam int DEPTH = 8;
   localparam int AF    = DEPTH - 2;

   logic       aclk;
   logic       aresetn;
   logic [7:0] s_axis_tdata;
   logic       s_axis_tvalid;
   logic       s_axis_tready;
   logic [7:0] m_axis_tdata;
   logic       m_axis_tvalid;
   logic       m_axis_tready;
   logic [3:0] count;
   logic       almost_full;

   int checks = 0;
   int errors = 0;
   int rx_cnt = 0;

   // Reference model: the FIFO contents as a plain queue of beats.
   logic [7:0] exp_q[$];
   bit         rst_done   = 1'b0;
   bit         stall_prev = 1'b0;
   logic [7:0] prev_data  = '0;

   axis_sync_fifo #(.TDATA_BYTES(1), .DEPTH(DEPTH), .ALMOST_FULL_LVL(AF)) dut (
      .aclk          (aclk),
      .aresetn       (aresetn),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tready (s_axis_tready),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .count         (count),
      .almost_full   (almost_full)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Advance n cycles, ending just after the rising edge.
   task automatic step(input int n);
      repeat (n) @(posedge aclk);
      #2;
   endtask

   // Present one beat and hold it until accepted (bounded).
   task automatic send(input logic [7:0] d);
      int n = 0;
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = d;
      while (1) begin
         @(negedge aclk);
         if (s_axis_tready === 1'b1) break;
         n++;
         if (n > 200) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: beat %0h not accepted, waited %0d cycles, limit 200", d, n);
            break;
         end
      end
      @(posedge aclk);
      #2;
      s_axis_tvalid = 1'b0;
   endtask

   // Monitor/scoreboard: mid-cycle, inputs and outputs are stable for the
   // coming edge. Expected flags come from queue occupancy; accepted beats
   // are pushed, popped beats are compared in order.
   always @(negedge aclk) begin
      bit exp_srdy;
      bit exp_mvld;
      bit wr;
      bit rd;
      if (!aresetn) begin
         exp_q.delete();
         rst_done   = 1'b0;
         stall_prev = 1'b0;
         chk("rst_s_tready", s_axis_tready, 0);
         chk("rst_m_tvalid", m_axis_tvalid, 0);
         chk("rst_count", count, 0);
         chk("rst_almost_full", almost_full, 0);
      end else begin
         exp_srdy = rst_done && (exp_q.size() != DEPTH);
         exp_mvld = (exp_q.size() != 0);
         chk("s_tready", s_axis_tready, exp_srdy);
         chk("m_tvalid", m_axis_tvalid, exp_mvld);
         chk("count", count, exp_q.size());
         chk("almost_full", almost_full, exp_q.size() >= AF);
         if (count > DEPTH) chk("count_bound", count, DEPTH);
         if (exp_mvld) chk("m_tdata", m_axis_tdata, exp_q[0]);
         if (stall_prev) chk("m_tdata_stable", m_axis_tdata, prev_data);
         wr = s_axis_tvalid && exp_srdy;
         rd = exp_mvld && m_axis_tready;
         if (rd) begin
            void'(exp_q.pop_front());
            rx_cnt++;
         end
         if (wr) exp_q.push_back(s_axis_tdata);
         stall_prev = exp_mvld && !m_axis_tready;
         prev_data  = m_axis_tdata;
         rst_done   = 1'b1;
      end
   end

   initial begin
      aresetn       = 1'b0;
      s_axis_tvalid = 1'b0;
      s_axis_tdata  = '0;
      m_axis_tready = 1'b0;

      // Reset then single beat.
      step(5);
      aresetn = 1'b1;
      chk("ready_not_yet", s_axis_tready, 0);
      step(1);
      chk("ready_after_release", s_axis_tready, 1);
      m_axis_tready = 1'b1;
      send(8'hA5);
      chk("single_count_1", count, 1);
      chk("single_tdata", m_axis_tdata, 8'hA5);
      step(1);
      chk("single_count_0", count, 0);
      step(2);

      // Fill to full, then offer a 9th beat that must be held.
      m_axis_tready = 1'b0;
      for (int i = 0; i < DEPTH; i++) send(8'(i));
      chk("full_count", count, DEPTH);
      chk("full_ready", s_axis_tready, 0);
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = 8'h08;
      step(4);
      s_axis_tvalid = 1'b0;
      chk("ninth_held_count", count, DEPTH);

      // Drain in order.
      m_axis_tready = 1'b1;
      step(10);
      chk("drain_count", count, 0);
      chk("drain_tvalid", m_axis_tvalid, 0);

      // Simultaneous pop and write attempt while full.
      m_axis_tready = 1'b0;
      for (int i = 0; i < DEPTH; i++) send(8'h10 + 8'(i));
      m_axis_tready = 1'b1;
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = 8'h55;
      step(1);
      m_axis_tready = 1'b0;
      chk("full_rw_count_7", count, 7);
      chk("full_rw_ready", s_axis_tready, 1);
      step(1);
      s_axis_tvalid = 1'b0;
      chk("full_rw_count_8", count, 8);
      m_axis_tready = 1'b1;
      step(12);
      chk("full_rw_drained", count, 0);

      // Wrap-around with random stalls on both sides.
      begin
         int target;
         target = rx_cnt + 1000;
         fork
            begin
               int wduty;
               wduty = $urandom_range(30, 90);
               for (int i = 0; i < 1000; i++) begin
                  if (i % 100 == 0) wduty = $urandom_range(30, 90);
                  while ($urandom_range(99) >= wduty) step(1);
                  send(8'(i));
               end
            end
            begin
               int rduty;
               int cyc;
               rduty = $urandom_range(30, 90);
               cyc   = 0;
               while (rx_cnt < target && cyc < 30000) begin
                  step(1);
                  m_axis_tready = ($urandom_range(99) < rduty);
                  cyc++;
                  if (cyc % 128 == 0) rduty = $urandom_range(30, 90);
               end
               if (rx_cnt < target) begin
                  checks++;
                  errors++;
                  $display("FAIL random_timeout: received %0d beats, expected %0d", rx_cnt, target);
               end
            end
         join
      end
      m_axis_tready = 1'b0;
      step(2);
      chk("random_empty", count, 0);

      // Reset mid-stream with five beats buffered.
      for (int i = 0; i < 5; i++) send(8'h30 + 8'(i));
      step(1);
      chk("pre_reset_count", count, 5);
      aresetn = 1'b0;
      #1;
      chk("async_m_tvalid", m_axis_tvalid, 0);
      chk("async_count", count, 0);
      chk("async_s_tready", s_axis_tready, 0);
      step(3);
      aresetn = 1'b1;
      m_axis_tready = 1'b1;
      step(6);
      chk("post_reset_tvalid", m_axis_tvalid, 0);
      send(8'h77);
      chk("post_reset_tdata", m_axis_tdata, 8'h77);
      step(3);

      chk("scoreboard_empty", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
